// File: rtl/bit_serial_alu_if.sv
// Operand/result handshake bundle for bit_serial_alu.
// The master side is the operand source and result sink. The slave side is the ALU.
interface bit_serial_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, sel, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, sel, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial logic unit: operands stream LSB-first through a one-bit ALU slice.
// The result word is assembled MSB-in and published once every bit is done.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for an operation; operands are latched on in_valid
// S_SHIFT | one bit per clock through the slice, WIDTH clocks in total
// S_DONE  | result presented, waiting for out_ready
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    bit_serial_alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y;
    logic [WIDTH-1:0] r_next;

    // One-bit slice: 00 OR, 01 AND, 10 NOR, 11 NAND
    function automatic logic bit_alu(input logic [1:0] s, input logic a, input logic b);
        logic r;
        case (s)
            2'b00:   r = a | b;
            2'b01:   r = a & b;
            2'b10:   r = ~(a | b);
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

    assign y      = bit_alu(sel_q, a_sh_q[0], b_sh_q[0]);
    assign r_next = {y, r_sh_q[WIDTH-1:1]};

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            result_q <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            result_q <= result_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath update; result only changes on the final bit
    // so the published word never shows a partially shifted value
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        result_d = result_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.op_a;
                    b_sh_d  = bus.op_b;
                    sel_d   = bus.sel;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                r_sh_d = r_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = r_next;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu (WIDTH=8).
module tb_bit_serial_alu;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bit_serial_alu_if #(.WIDTH(8)) bus ();

    bit_serial_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Word-level reference: the whole operation is just a bitwise logic op
    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] s);
        case (s)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return ~(a | b);
            default: return ~(a & b);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation. Latency is the index of the first edge after the
    // accepting edge at which out_valid is seen high.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                          input int hold, input bit disturb,
                          output logic [7:0] res, output int lat);
        int         guard;
        logic [7:0] first;
        lat = -1;
        res = '0;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sel      = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = e;
                break;
            end
            if (disturb) begin
                bus.op_a      = 8'($urandom);
                bus.op_b      = 8'($urandom);
                bus.sel       = 2'($urandom);
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        if (lat < 0) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        first = bus.result;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_result", 32'(bus.result), 32'(first));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_busy", 32'(bus.busy), 32'd1);
        end
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        res = bus.result;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("consumed_out_valid", 32'(bus.out_valid), 32'd0);
        chk("consumed_in_ready", 32'(bus.in_ready), 32'd1);
        chk("keep_result", 32'(bus.result), 32'(res));
    endtask

    initial begin
        logic [7:0] res;
        int         lat;
        logic [7:0] pats [4];
        logic [7:0] ra, rb;
        logic [1:0] rs;

        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;

        // Known-answer vectors first, then the exhaustive pattern grid
        vecs.push_back('{8'hF0, 8'hCC, 2'b00, 8'hFC});
        vecs.push_back('{8'hF0, 8'hCC, 2'b01, 8'hC0});
        vecs.push_back('{8'hF0, 8'hCC, 2'b10, 8'h03});
        vecs.push_back('{8'hF0, 8'hCC, 2'b11, 8'h3F});
        pats = '{8'h00, 8'hFF, 8'hAA, 8'h55};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    vecs.push_back('{pats[i], pats[j], 2'(k), ref_op(pats[i], pats[j], 2'(k))});

        foreach (vecs[n]) begin
            run_op(vecs[n].a, vecs[n].b, vecs[n].sel, 0, 1'b0, res, lat);
            chk("vec_latency", 32'(lat), 32'd9);
            chk($sformatf("vec%0d_result", n), 32'(res), 32'(vecs[n].exp));
        end

        // Sink stalls for 5 cycles in DONE
        run_op(8'hA5, 8'h3C, 2'b01, 5, 1'b0, res, lat);
        chk("stall_result", 32'(res), 32'(8'h24));

        // Inputs wiggled and in_valid pulsed while busy
        run_op(8'hF0, 8'hCC, 2'b01, 0, 1'b1, res, lat);
        chk("disturb_latency", 32'(lat), 32'd9);
        chk("disturb_result", 32'(res), 32'(8'hC0));
        repeat (12) begin
            @(negedge clk);
            chk("no_second_op", 32'(bus.busy), 32'd0);
        end

        // Reset applied at the 4th SHIFT edge
        @(negedge clk);
        bus.op_a     = 8'h0F;
        bus.op_b     = 8'h33;
        bus.sel      = 2'b11;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
        end
        run_op(8'h00, 8'hFF, 2'b00, 0, 1'b0, res, lat);
        chk("post_reset_latency", 32'(lat), 32'd9);
        chk("post_reset_result", 32'(res), 32'(8'hFF));

        // Random operations against the word-level model
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 2'($urandom);
            run_op(ra, rb, rs, $urandom_range(0, 3), 1'($urandom_range(0, 1)), res, lat);
            chk("rand_latency", 32'(lat), 32'd9);
            chk($sformatf("rand%0d_result", n), 32'(res), 32'(ref_op(ra, rb, rs)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
